mem_dma_arb: RTL

Single-port access controller in front of the 8x256 data memory. It shares the memory's one address/write port between the CPU load/store path and an internal block-copy (DMA) engine. The CPU has priority, and a starvation counter guarantees the DMA forward progress. The block sits between the CPU datapath and data memory, and drives the memory's WriteEn, DataAddress and DataIn directly.

---
 rtl/mem_dma_arb.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/mem_dma_arb.sv
// Single-port access controller for the data memory.
// The CPU load/store path and a byte block-copy engine share one
// address/write port. The CPU normally wins; a saturating wait counter
// forces one DMA slot after MAX_WAIT consecutive stalled DMA cycles.
module mem_dma_arb #(
    parameter int W        = 8,
    parameter int A        = 8,
    parameter int MAX_WAIT = 4
) (
    input  logic         Clk,
    input  logic         Reset,
    // CPU side
    input  logic         CpuReq,
    input  logic         CpuWriteEn,
    input  logic [A-1:0] CpuAddr,
    input  logic [W-1:0] CpuDataIn,
    output logic         CpuGrant,
    output logic [W-1:0] CpuDataOut,
    // copy engine control
    input  logic         Start,
    input  logic [A-1:0] SrcAddr,
    input  logic [A-1:0] DstAddr,
    input  logic [A-1:0] Len,
    output logic         Busy,
    output logic         Done,
    // memory side
    output logic         MemWriteEn,
    output logic [A-1:0] MemAddr,
    output logic [W-1:0] MemDataIn,
    input  logic [W-1:0] MemDataOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [3:0]   MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [A-1:0] ONE_A      = A'(1);

    state_t         state_q;
    logic [A-1:0]   src_q;
    logic [A-1:0]   dst_q;
    logic [A-1:0]   cnt_q;
    logic [W-1:0]   buf_q;
    logic [3:0]     wait_q;
    logic [3:0]     wait_d;
    logic           busy_q;
    logic           done_q;

    logic           dma_wants;
    logic           force_slot;
    logic           cpu_grant;
    logic           dma_owns;

    // Arbitration, port mux and next wait count; reset blanks the port so a
    // copy interrupted mid-write cannot commit anything.
    always_comb begin
        dma_wants  = (state_q == RD) || (state_q == WR);
        force_slot = (wait_q == MAX_WAIT_C);
        cpu_grant  = CpuReq && !(dma_wants && force_slot) && !Reset;
        dma_owns   = dma_wants && !cpu_grant && !Reset;

        MemWriteEn = 1'b0;
        MemAddr    = '0;
        MemDataIn  = '0;
        if (cpu_grant) begin
            MemWriteEn = CpuWriteEn;
            MemAddr    = CpuAddr;
            MemDataIn  = CpuDataIn;
        end else if (dma_owns) begin
            if (state_q == RD) begin
                MemAddr = src_q;
            end else begin
                MemWriteEn = 1'b1;
                MemAddr    = dst_q;
                MemDataIn  = buf_q;
            end
        end

        // Count only cycles where the DMA was refused; any granted DMA slot
        // or a non-transfer state starts the count over.
        if (!dma_wants || dma_owns) begin
            wait_d = '0;
        end else if (wait_q != MAX_WAIT_C) begin
            wait_d = wait_q + 4'd1;
        end else begin
            wait_d = wait_q;
        end
    end

    assign CpuGrant   = cpu_grant;
    assign CpuDataOut = MemDataOut;
    assign Busy       = busy_q;
    assign Done       = done_q;

    // Copy-engine FSM with registered Busy/Done; stalled RD/WR hold state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            wait_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            // Done is raised from the FIN cycle so it lands as IDLE resumes.
            done_q <= (state_q == FIN);
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        src_q <= SrcAddr;
                        dst_q <= DstAddr;
                        cnt_q <= Len;
                        if (Len != '0) begin
                            state_q <= RD;
                            busy_q  <= 1'b1;
                        end else begin
                            state_q <= FIN;
                        end
                    end
                end
                RD: begin
                    if (dma_owns) begin
                        buf_q   <= MemDataOut;
                        state_q <= WR;
                    end
                end
                WR: begin
                    if (dma_owns) begin
                        src_q <= src_q + ONE_A;
                        dst_q <= dst_q + ONE_A;
                        cnt_q <= cnt_q - ONE_A;
                        if (cnt_q == ONE_A) begin
                            state_q <= FIN;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q <= RD;
                        end
                    end
                end
                FIN: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
